// File: rtl/rtc_fmt_pkg.sv
// Shared constants, state encoding and BCD digit conversion for the RTC-to-UART line formatter.
package rtc_fmt_pkg;

  localparam int unsigned FRAME_LEN = 23;

  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] DASH  = 8'h2D;
  localparam logic [7:0] COLON = 8'h3A;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] QMARK = 8'h3F;

  typedef enum logic [1:0] {IDLE, WAIT_RD, SEND} state_e;

  // Non-decimal nibbles are shown as '?' rather than flagged.
  function automatic logic [7:0] bcd2ascii(input logic [3:0] nibble);
    if (nibble > 4'd9) begin
      return QMARK;
    end
    return ZERO + {4'h0, nibble};
  endfunction

endpackage

// File: rtl/rtc_frame_char.sv
// Combinational character lookup: frame index plus masked snapshot -> ASCII byte of
// "20YY-MM-DD d HH:MM:SS\r\n".
module rtc_frame_char
  import rtc_fmt_pkg::*;
(
  input  logic [4:0] index,
  input  logic [7:0] yrVal,
  input  logic [7:0] monVal,
  input  logic [7:0] dateVal,
  input  logic [7:0] dayVal,
  input  logic [7:0] hrsVal,
  input  logic [7:0] minVal,
  input  logic [7:0] secVal,
  output logic [7:0] charOut
);

  always_comb begin
    charOut = 8'h00;
    case (index)
      5'd0:    charOut = bcd2ascii(4'd2);
      5'd1:    charOut = bcd2ascii(4'd0);
      5'd2:    charOut = bcd2ascii(yrVal[7:4]);
      5'd3:    charOut = bcd2ascii(yrVal[3:0]);
      5'd4:    charOut = DASH;
      5'd5:    charOut = bcd2ascii(monVal[7:4]);
      5'd6:    charOut = bcd2ascii(monVal[3:0]);
      5'd7:    charOut = DASH;
      5'd8:    charOut = bcd2ascii(dateVal[7:4]);
      5'd9:    charOut = bcd2ascii(dateVal[3:0]);
      5'd10:   charOut = SPACE;
      5'd11:   charOut = bcd2ascii(dayVal[3:0]);
      5'd12:   charOut = SPACE;
      5'd13:   charOut = bcd2ascii(hrsVal[7:4]);
      5'd14:   charOut = bcd2ascii(hrsVal[3:0]);
      5'd15:   charOut = COLON;
      5'd16:   charOut = bcd2ascii(minVal[7:4]);
      5'd17:   charOut = bcd2ascii(minVal[3:0]);
      5'd18:   charOut = COLON;
      5'd19:   charOut = bcd2ascii(secVal[7:4]);
      5'd20:   charOut = bcd2ascii(secVal[3:0]);
      5'd21:   charOut = CR;
      5'd22:   charOut = LF;
      default: charOut = 8'h00;
    endcase
  end

endmodule

// File: rtl/rtc_uart_formatter.sv
// Periodically triggers the DS1302 reader, snapshots its BCD registers and streams them as one
// ASCII line over a valid/ready byte handshake.
module rtc_uart_formatter
  import rtc_fmt_pkg::*;
#(
  parameter int unsigned TRIG_PERIOD = 100_000_000,
  parameter int unsigned RD_TIMEOUT  = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       rdEn,
  input  logic [7:0] secData,
  input  logic [7:0] minData,
  input  logic [7:0] hrsData,
  input  logic [7:0] dateData,
  input  logic [7:0] monData,
  input  logic [7:0] dayData,
  input  logic [7:0] yrData,
  input  logic       dataValid,
  output logic [7:0] txData,
  output logic       txValid,
  input  logic       txReady,
  output logic       busy,
  output logic       frameDone,
  output logic       rdErr
);

  localparam int unsigned TimerW = $clog2(TRIG_PERIOD);
  localparam int unsigned ToW    = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

  state_e            stateQ, stateD;
  logic [TimerW-1:0] timerQ;
  logic [ToW-1:0]    toCntQ, toCntD;
  logic [4:0]        idxQ, idxD;
  logic              frameDoneQ, frameDoneD;
  logic              latch;
  logic              tick;
  logic [7:0]        secQ, minQ, hrsQ, dateQ, monQ, dayQ, yrQ;
  logic [7:0]        charOut;

  assign tick = (timerQ == TimerW'(TRIG_PERIOD - 1));

  // Timer is held at zero while disabled so re-enabling restarts a full period.
  always_ff @(posedge clk) begin
    if (!rst) begin
      timerQ <= '0;
    end else if (!enable || tick) begin
      timerQ <= '0;
    end else begin
      timerQ <= timerQ + TimerW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stateQ     <= IDLE;
      toCntQ     <= '0;
      idxQ       <= '0;
      frameDoneQ <= 1'b0;
    end else begin
      stateQ     <= stateD;
      toCntQ     <= toCntD;
      idxQ       <= idxD;
      frameDoneQ <= frameDoneD;
    end
  end

  // Field masks strip flag bits so only the displayed digits are kept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      secQ  <= '0;
      minQ  <= '0;
      hrsQ  <= '0;
      dateQ <= '0;
      monQ  <= '0;
      dayQ  <= '0;
      yrQ   <= '0;
    end else if (latch) begin
      secQ  <= {1'b0, secData[6:0]};
      minQ  <= {1'b0, minData[6:0]};
      hrsQ  <= hrsData[7] ? {3'b000, hrsData[4:0]} : {2'b00, hrsData[5:0]};
      dateQ <= {2'b00, dateData[5:0]};
      monQ  <= {3'b000, monData[4:0]};
      dayQ  <= {5'b00000, dayData[2:0]};
      yrQ   <= yrData;
    end
  end

  always_comb begin
    stateD     = stateQ;
    toCntD     = toCntQ;
    idxD       = idxQ;
    frameDoneD = 1'b0;
    latch      = 1'b0;
    rdEn       = 1'b0;
    rdErr      = 1'b0;
    unique case (stateQ)
      IDLE: begin
        if (tick && enable) begin
          rdEn   = 1'b1;
          toCntD = '0;
          stateD = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (dataValid) begin
          latch  = 1'b1;
          idxD   = '0;
          stateD = SEND;
        end else if (toCntQ == ToW'(RD_TIMEOUT - 1)) begin
          rdErr  = 1'b1;
          stateD = IDLE;
        end else begin
          toCntD = toCntQ + ToW'(1);
        end
      end
      SEND: begin
        if (txReady) begin
          if (idxQ == 5'(FRAME_LEN - 1)) begin
            frameDoneD = 1'b1;
            idxD       = '0;
            stateD     = IDLE;
          end else begin
            idxD = idxQ + 5'd1;
          end
        end
      end
      default: stateD = IDLE;
    endcase
  end

  rtc_frame_char uChar (
    .index   (idxQ),
    .yrVal   (yrQ),
    .monVal  (monQ),
    .dateVal (dateQ),
    .dayVal  (dayQ),
    .hrsVal  (hrsQ),
    .minVal  (minQ),
    .secVal  (secQ),
    .charOut (charOut)
  );

  assign txValid   = (stateQ == SEND);
  assign txData    = txValid ? charOut : 8'h00;
  assign busy      = (stateQ != IDLE);
  assign frameDone = frameDoneQ;

endmodule

// File: tb/tb_rtc_uart_formatter.sv
// Randomised bench for rtc_uart_formatter against a string-level model of the output line.
module tb_rtc_uart_formatter;

  localparam int unsigned TrigPeriod = 100;
  localparam int unsigned RdTimeout  = 50;
  localparam int          FrameLen   = 23;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       dataValid = 1'b0;
  logic       txReady = 1'b0;
  logic [7:0] secData = '0, minData = '0, hrsData = '0, dateData = '0;
  logic [7:0] monData = '0, dayData = '0, yrData = '0;
  logic       rdEn, txValid, busy, frameDone, rdErr;
  logic [7:0] txData;

  logic [7:0] expFrame [FrameLen];
  int         nCompared = 0;
  int         nMismatched = 0;

  always #5 clk = ~clk;

  rtc_uart_formatter #(
    .TRIG_PERIOD (TrigPeriod),
    .RD_TIMEOUT  (RdTimeout)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .rdEn      (rdEn),
    .secData   (secData),
    .minData   (minData),
    .hrsData   (hrsData),
    .dateData  (dateData),
    .monData   (monData),
    .dayData   (dayData),
    .yrData    (yrData),
    .dataValid (dataValid),
    .txData    (txData),
    .txValid   (txValid),
    .txReady   (txReady),
    .busy      (busy),
    .frameDone (frameDone),
    .rdErr     (rdErr)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] digit(input int v);
    return (v > 9) ? 8'h3F : 8'(48 + v);
  endfunction

  // Expected line built from field values with plain arithmetic (modulo masks, div/mod by 16).
  task automatic buildExp(input logic [7:0] yr, input logic [7:0] mon, input logic [7:0] date,
                          input logic [7:0] day, input logic [7:0] hrs, input logic [7:0] mn,
                          input logic [7:0] sc);
    int y, mo, d, dw, h, m, s;
    y  = int'(yr);
    mo = int'(mon) % 32;
    d  = int'(date) % 64;
    dw = int'(day) % 8;
    h  = (int'(hrs) >= 128) ? int'(hrs) % 32 : int'(hrs) % 64;
    m  = int'(mn) % 128;
    s  = int'(sc) % 128;
    expFrame[0]  = 8'h32;         expFrame[1]  = 8'h30;
    expFrame[2]  = digit(y / 16); expFrame[3]  = digit(y % 16);
    expFrame[4]  = 8'h2D;
    expFrame[5]  = digit(mo / 16); expFrame[6] = digit(mo % 16);
    expFrame[7]  = 8'h2D;
    expFrame[8]  = digit(d / 16); expFrame[9]  = digit(d % 16);
    expFrame[10] = 8'h20;         expFrame[11] = digit(dw);
    expFrame[12] = 8'h20;
    expFrame[13] = digit(h / 16); expFrame[14] = digit(h % 16);
    expFrame[15] = 8'h3A;
    expFrame[16] = digit(m / 16); expFrame[17] = digit(m % 16);
    expFrame[18] = 8'h3A;
    expFrame[19] = digit(s / 16); expFrame[20] = digit(s % 16);
    expFrame[21] = 8'h0D;         expFrame[22] = 8'h0A;
  endtask

  function automatic logic [7:0] randBcd();
    if ($urandom_range(0, 3) == 0) return 8'($urandom);
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  task automatic scrambleInputs();
    secData  = 8'($urandom); minData = 8'($urandom); hrsData = 8'($urandom);
    dateData = 8'($urandom); monData = 8'($urandom); dayData = 8'($urandom);
    yrData   = 8'($urandom);
  endtask

  // Returns at the negedge where rdEn is seen (or the bound expires); waited = cycles elapsed.
  task automatic waitRdEn(input int limit, output int waited);
    waited = 0;
    while (waited < limit) begin
      @(negedge clk);
      waited++;
      if (rdEn) break;
    end
    checkVal("trigSeen", 32'(rdEn), 32'd1);
  endtask

  // Entered at the negedge where rdEn is high. mode 0: ready always, 1: ready 1 of 3, 2: random.
  task automatic runFrame(input int mode, input logic [7:0] yr, input logic [7:0] mon,
                          input logic [7:0] date, input logic [7:0] day, input logic [7:0] hrs,
                          input logic [7:0] mn, input logic [7:0] sc, input int dropEnAt,
                          input int abortAt);
    int n, firstC, lastC;
    bit stalled, done;
    logic [7:0] held;
    buildExp(yr, mon, date, day, hrs, mn, sc);
    repeat ($urandom_range(1, 10)) @(negedge clk);
    yrData = yr; monData = mon; dateData = date; dayData = day;
    hrsData = hrs; minData = mn; secData = sc;
    dataValid = 1'b1;
    @(negedge clk);
    dataValid = 1'b0;
    scrambleInputs();
    checkVal("latency", 32'(txValid), 32'd1);
    n = 0; firstC = 0; lastC = 0; stalled = 1'b0; done = 1'b0; held = '0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (n == FrameLen) begin
        checkVal("frameDone", 32'(frameDone), 32'd1);
        checkVal("validDrop", 32'(txValid), 32'd0);
        txReady = 1'b0; dataValid = 1'b0;
        done = 1'b1;
      end else if (n == abortAt) begin
        rst = 1'b0; txReady = 1'b0; dataValid = 1'b0;
        @(negedge clk);
        checkVal("abortValid", 32'(txValid), 32'd0);
        checkVal("abortData", 32'(txData), 32'd0);
        checkVal("abortBusy", 32'(busy), 32'd0);
        rst = 1'b1;
        done = 1'b1;
      end else begin
        checkVal("txValid", 32'(txValid), 32'd1);
        checkVal("noDoneYet", 32'(frameDone), 32'd0);
        checkVal("noRdErr", 32'(rdErr | rdEn), 32'd0);
        if (stalled) checkVal("stable", 32'(txData), 32'(held));
        if (n == dropEnAt) enable = 1'b0;
        case (mode)
          0:       txReady = 1'b1;
          1:       txReady = ((c % 3) == 2);
          default: txReady = 1'($urandom_range(0, 1));
        endcase
        if (txReady) begin
          checkVal($sformatf("byte%0d", n), 32'(txData), 32'(expFrame[n]));
          if (n == 0) firstC = c;
          if (n == FrameLen - 1) lastC = c;
          n++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = txData;
        end
        // Stray dataValid during SEND must not disturb the snapshot.
        if (mode == 2) begin
          scrambleInputs();
          dataValid = ($urandom_range(0, 7) == 0);
        end else begin
          dataValid = 1'b0;
        end
        @(negedge clk);
      end
    end
    if (abortAt < 0) checkVal("frameLen", 32'(n), 32'(FrameLen));
    if (mode == 0 && abortAt < 0) checkVal("backToBack", 32'(lastC - firstC), 32'd22);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w, k, seen;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    checkVal("resetOut", 32'({rdEn, txValid, busy, frameDone, rdErr, txData}), 32'd0);
    rst = 1'b1;

    // First trigger after reset, then read timeout and retrigger one period later.
    waitRdEn(200, w);
    checkVal("firstTrig", 32'(w), 32'd99);
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (rdErr) break;
    end
    checkVal("rdErrDelay", 32'(k), 32'(RdTimeout));
    @(negedge clk);
    checkVal("idleAfterErr", 32'(busy), 32'd0);
    waitRdEn(200, w);
    checkVal("period", 32'(k + 1 + w), 32'(TrigPeriod));

    runFrame(0, 8'h25, 8'h07, 8'h14, 8'h01, 8'h09, 8'h05, 8'h3A, -1, -1);
    waitRdEn(300, w);
    runFrame(1, 8'h25, 8'h07, 8'h14, 8'h01, 8'h09, 8'h05, 8'h3A, -1, -1);
    waitRdEn(300, w);
    runFrame(0, 8'h25, 8'h07, 8'h14, 8'h01, 8'h92, 8'h05, 8'hD9, -1, -1);
    for (int f = 0; f < 3; f++) begin
      waitRdEn(300, w);
      runFrame(2, randBcd(), randBcd(), randBcd(), randBcd(),
               randBcd() | ($urandom_range(0, 1) ? 8'h80 : 8'h00), randBcd(), randBcd(),
               (f == 2) ? 5 : -1, -1);
    end

    // Enable was dropped mid-frame: frame completed, now no triggers until re-enabled.
    seen = 0;
    repeat (250) begin
      @(negedge clk);
      if (rdEn) seen++;
    end
    checkVal("noTrigDisabled", 32'(seen), 32'd0);
    enable = 1'b1;
    waitRdEn(200, w);
    checkVal("reenableTrig", 32'(w), 32'd99);

    runFrame(0, randBcd(), randBcd(), randBcd(), randBcd(), randBcd(), randBcd(), randBcd(),
             -1, 10);
    waitRdEn(200, w);
    checkVal("trigAfterAbort", 32'(w), 32'd99);
    runFrame(2, randBcd(), randBcd(), randBcd(), randBcd(), randBcd(), randBcd(), randBcd(),
             -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
